// File: rtl/ahmes_alu.sv
// Ahmes CPU datapath ALU: add/sub, bitwise logic, shifts and rotates.
// Result and NZCBV flags are registered, giving one clock of latency.
module ahmes_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       operacao,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic             Cin,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             B,
  output logic             V
);

  typedef enum logic [3:0] {
    OP_PASS = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_ROL  = 4'b0111,
    OP_ROR  = 4'b1000,
    OP_SHL  = 4'b1001,
    OP_SHR  = 4'b1010
  } op_e;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_b;
  logic             w_v;

  assign w_sum  = {1'b0, operA} + {1'b0, operB};
  assign w_diff = {1'b0, operA} - {1'b0, operB};

  always_comb begin
    w_res = operA;
    w_c   = 1'b0;
    w_b   = 1'b0;
    w_v   = 1'b0;
    case (operacao)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (operA[WIDTH-1] == operB[WIDTH-1]) && (w_sum[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the unsigned borrow.
        w_res = w_diff[WIDTH-1:0];
        w_b   = w_diff[WIDTH];
        w_v   = (operA[WIDTH-1] != operB[WIDTH-1]) && (w_diff[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_OR:  w_res = operA | operB;
      OP_AND: w_res = operA & operB;
      OP_NOT: w_res = ~operA;
      OP_XOR: w_res = operA ^ operB;
      OP_ROL: begin
        w_res = {operA[WIDTH-2:0], Cin};
        w_c   = operA[WIDTH-1];
      end
      OP_ROR: begin
        w_res = {Cin, operA[WIDTH-1:1]};
        w_c   = operA[0];
      end
      OP_SHL: begin
        w_res = {operA[WIDTH-2:0], 1'b0};
        w_c   = operA[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, operA[WIDTH-1:1]};
        w_c   = operA[0];
      end
      default: w_res = operA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
      C      <= 1'b0;
      B      <= 1'b0;
      V      <= 1'b0;
    end else begin
      result <= w_res;
      N      <= w_res[WIDTH-1];
      Z      <= (w_res == '0);
      C      <= w_c;
      B      <= w_b;
      V      <= w_v;
    end
  end

endmodule

// File: tb/tb_ahmes_alu.sv
// Directed self-checking bench for ahmes_alu; expected values are hand-computed.
module tb_ahmes_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] operacao;
  logic [7:0] operA;
  logic [7:0] operB;
  logic       Cin;
  logic [7:0] result;
  logic       N, Z, C, B, V;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  ahmes_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .operacao(operacao), .operA(operA), .operB(operB),
    .Cin(Cin), .result(result), .N(N), .Z(Z), .C(C), .B(B), .V(V)
  );

  always #5 clk = ~clk;

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic apply(input logic r, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    @(negedge clk);
    rst = r; operacao = op; operA = a; operB = b; Cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(1'b1, 4'b0001, 8'd255, 8'd1, 1'b1);
    apply(1'b1, 4'b0001, 8'd255, 8'd1, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b00000}) begin
      n_fails++;
      $display("FAIL reset: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=00000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0001, 8'd10, 8'd20, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd30, 5'b00000}) begin
      n_fails++;
      $display("FAIL add_10_20: got R=%0d NZCBV=%b%b%b%b%b, want R=30 NZCBV=00000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_add;
    apply(1'b0, 4'b0001, 8'd255, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b01100}) begin
      n_fails++;
      $display("FAIL add_255_1: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=01100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0001, 8'd127, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd128, 5'b10001}) begin
      n_fails++;
      $display("FAIL add_127_1: got R=%0d NZCBV=%b%b%b%b%b, want R=128 NZCBV=10001", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0001, 8'd10, 8'd20, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd30, 5'b00000}) begin
      n_fails++;
      $display("FAIL add_cin_ignored: got R=%0d NZCBV=%b%b%b%b%b, want R=30 NZCBV=00000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_sub;
    apply(1'b0, 4'b0010, 8'd50, 8'd20, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd30, 5'b00000}) begin
      n_fails++;
      $display("FAIL sub_50_20: got R=%0d NZCBV=%b%b%b%b%b, want R=30 NZCBV=00000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0010, 8'd0, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd255, 5'b10010}) begin
      n_fails++;
      $display("FAIL sub_0_1: got R=%0d NZCBV=%b%b%b%b%b, want R=255 NZCBV=10010", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0010, 8'd128, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd127, 5'b00001}) begin
      n_fails++;
      $display("FAIL sub_128_1: got R=%0d NZCBV=%b%b%b%b%b, want R=127 NZCBV=00001", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0010, 8'd77, 8'd77, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b01000}) begin
      n_fails++;
      $display("FAIL sub_equal: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=01000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_logic;
    apply(1'b0, 4'b0011, 8'd170, 8'd85, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd255, 5'b10000}) begin
      n_fails++;
      $display("FAIL or: got R=%0d NZCBV=%b%b%b%b%b, want R=255 NZCBV=10000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0101, 8'd240, 8'd255, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd15, 5'b00000}) begin
      n_fails++;
      $display("FAIL not: got R=%0d NZCBV=%b%b%b%b%b, want R=15 NZCBV=00000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0100, 8'd240, 8'd170, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd160, 5'b10000}) begin
      n_fails++;
      $display("FAIL and: got R=%0d NZCBV=%b%b%b%b%b, want R=160 NZCBV=10000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0110, 8'd240, 8'd170, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd90, 5'b00000}) begin
      n_fails++;
      $display("FAIL xor: got R=%0d NZCBV=%b%b%b%b%b, want R=90 NZCBV=00000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0110, 8'd99, 8'd99, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b01000}) begin
      n_fails++;
      $display("FAIL xor_zero: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=01000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_shift;
    apply(1'b0, 4'b0111, 8'd129, 8'd0, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd3, 5'b00100}) begin
      n_fails++;
      $display("FAIL rol_129: got R=%0d NZCBV=%b%b%b%b%b, want R=3 NZCBV=00100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b1000, 8'd129, 8'd0, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd192, 5'b10100}) begin
      n_fails++;
      $display("FAIL ror_129: got R=%0d NZCBV=%b%b%b%b%b, want R=192 NZCBV=10100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b1001, 8'd129, 8'd0, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd2, 5'b00100}) begin
      n_fails++;
      $display("FAIL shl_129: got R=%0d NZCBV=%b%b%b%b%b, want R=2 NZCBV=00100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b1010, 8'd129, 8'd0, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd64, 5'b00100}) begin
      n_fails++;
      $display("FAIL shr_129: got R=%0d NZCBV=%b%b%b%b%b, want R=64 NZCBV=00100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0111, 8'd64, 8'd0, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd128, 5'b10000}) begin
      n_fails++;
      $display("FAIL rol_64_c0: got R=%0d NZCBV=%b%b%b%b%b, want R=128 NZCBV=10000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b1000, 8'd2, 8'd0, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd1, 5'b00000}) begin
      n_fails++;
      $display("FAIL ror_2_c0: got R=%0d NZCBV=%b%b%b%b%b, want R=1 NZCBV=00000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_passthrough;
    apply(1'b0, 4'b1111, 8'd0, 8'd55, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b01000}) begin
      n_fails++;
      $display("FAIL pass_1111: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=01000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0000, 8'h85, 8'd1, 1'b1);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'h85, 5'b10000}) begin
      n_fails++;
      $display("FAIL pass_0000: got R=%0d NZCBV=%b%b%b%b%b, want R=133 NZCBV=10000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b1011, 8'h7F, 8'hFF, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'h7F, 5'b00000}) begin
      n_fails++;
      $display("FAIL pass_1011: got R=%0d NZCBV=%b%b%b%b%b, want R=127 NZCBV=00000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_back_to_back;
    // Flags from a carry-producing op must not linger into the next logic op.
    apply(1'b0, 4'b1001, 8'h80, 8'd0, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b01100}) begin
      n_fails++;
      $display("FAIL b2b_shl: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=01100", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0010, 8'd5, 8'd7, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd254, 5'b10010}) begin
      n_fails++;
      $display("FAIL b2b_sub: got R=%0d NZCBV=%b%b%b%b%b, want R=254 NZCBV=10010", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0011, 8'd1, 8'd2, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd3, 5'b00000}) begin
      n_fails++;
      $display("FAIL b2b_or: got R=%0d NZCBV=%b%b%b%b%b, want R=3 NZCBV=00000", result, N, Z, C, B, V);
    end
  endtask

  task automatic test_reset_midstream;
    apply(1'b0, 4'b0001, 8'd127, 8'd1, 1'b0);
    apply(1'b1, 4'b0010, 8'd0, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd0, 5'b00000}) begin
      n_fails++;
      $display("FAIL rst_mid: got R=%0d NZCBV=%b%b%b%b%b, want R=0 NZCBV=00000", result, N, Z, C, B, V);
    end
    apply(1'b0, 4'b0010, 8'd0, 8'd1, 1'b0);
    n_checks++;
    if ({result, N, Z, C, B, V} !== {8'd255, 5'b10010}) begin
      n_fails++;
      $display("FAIL rst_release: got R=%0d NZCBV=%b%b%b%b%b, want R=255 NZCBV=10010", result, N, Z, C, B, V);
    end
  endtask

  initial begin
    rst = 1'b1; operacao = '0; operA = '0; operB = '0; Cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_passthrough();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units, expected completion earlier");
    $fatal(1, "timeout");
  end

endmodule
